// File: rtl/rot_result_fifo_if.sv
// Handshake bundle between the rotator-side producer, the result FIFO and the writeback consumer.
// The FIFO takes the slave view; the producer/consumer side takes the master view.
interface rot_result_fifo_if #(
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned SEL_W  = 2,
  localparam int unsigned ONES_W = $clog2(DATA_W + 1)
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic [SEL_W-1:0]  wr_sel;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_zero;
  logic [ONES_W-1:0] rd_ones;

  modport master (
    output wr_valid, wr_data, wr_sel, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_sel, rd_zero, rd_ones
  );

  modport slave (
    input  wr_valid, wr_data, wr_sel, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_sel, rd_zero, rd_ones
  );

endinterface

// File: rtl/rot_result_fifo.sv
// First-word-fall-through FIFO buffering rotator results with their tag and precomputed flags.
// Every output comes straight from a flop; the head entry is re-registered from next-state values.
module rot_result_fifo #(
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned SEL_W  = 2,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1,
  localparam int unsigned ONES_W = $clog2(DATA_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  rot_result_fifo_if.slave      bus,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  input  logic                  clr_ovf
);

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
    logic              zero;
    logic [ONES_W-1:0] ones;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               wr_ready_q, wr_ready_d;
  logic               rd_valid_q, rd_valid_d;
  entry_t             head_q, head_d;
  entry_t             wr_entry;
  logic               push;
  logic               pop;

  // Flags are derived on the write side so the read path is a plain register.
  always_comb begin
    wr_entry      = '0;
    wr_entry.sel  = bus.wr_sel;
    wr_entry.data = bus.wr_data;
    wr_entry.zero = (bus.wr_data == '0);
    for (int unsigned i = 0; i < DATA_W; i++) begin
      wr_entry.ones = wr_entry.ones + ONES_W'(bus.wr_data[i]);
    end
  end

  assign push = bus.wr_valid & wr_ready_q;
  assign pop  = rd_valid_q & bus.rd_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A dropped push wins over a clear arriving in the same cycle.
    if (bus.wr_valid && !wr_ready_q) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end

    wr_ready_d = (count_d != CNT_W'(DEPTH));
    rd_valid_d = (count_d != '0);
    // mem_d already holds this cycle's write, covering a push into an empty FIFO.
    head_d     = rd_valid_d ? mem_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      wr_ready_q <= 1'b1;
      rd_valid_q <= 1'b0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      wr_ready_q <= wr_ready_d;
      rd_valid_q <= rd_valid_d;
      head_q     <= head_d;
    end
  end

  // Storage needs no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end
  end

  assign bus.wr_ready = wr_ready_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = head_q.data;
  assign bus.rd_sel   = head_q.sel;
  assign bus.rd_zero  = head_q.zero;
  assign bus.rd_ones  = head_q.ones;
  assign count        = count_q;
  assign overflow     = ovf_q;

endmodule

// File: doc/rot_result_fifo.md
Name: rot_result_fifo

Overview:
- Downstream consumer of the 4-bit rotator in the datapath.
- Captures each rotator result with its 2-bit selection tag and derived flags, then buffers it in a small first-word-fall-through FIFO.
- The downstream ALU/register-writeback stage drains the FIFO with a valid/ready handshake.
- Decouples the combinational rotator from writeback stalls and reports overflow instead of silently stalling the upstream.

Parameters:
- DATA_W, 4, width of the rotator result word.
- SEL_W, 2, width of the selection tag stored with each result.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- PTR_W, log2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- wr_valid  input  1  rotator result on wr_data/wr_sel is valid this cycle.
- wr_ready  output  1  FIFO can accept a push this cycle.
- wr_data  input  DATA_W  rotator output word.
- wr_sel  input  SEL_W  selection value that produced wr_data.
- rd_valid  output  1  head entry is valid.
- rd_ready  input  1  consumer accepts the head entry this cycle.
- rd_data  output  DATA_W  head entry data.
- rd_sel  output  SEL_W  head entry selection tag.
- rd_zero  output  1  head entry data == 0.
- rd_ones  output  3  popcount of head entry data, range 0..4.
- count  output  PTR_W+1  current occupancy, range 0..DEPTH.
- overflow  output  1  sticky: a push was attempted while full.
- clr_ovf  input  1  clears overflow.

Behaviour:
- Interface: one clock, clk; reset is rst, synchronous and active-high.
- Reset:
  - count=0, write and read pointers=0, overflow=0.
  - rd_valid=0, rd_data=0, rd_sel=0, rd_zero=0, rd_ones=0.
  - wr_ready=1 in the first cycle after reset.
  - Storage array contents are don't-care.
- Reset mid-operation discards all entries and clears overflow; the push/pop presented in that cycle is ignored.
- Push condition: push = wr_valid & wr_ready.
- wr_ready = (count != DEPTH). It depends only on registered count, never on rd_ready in the same cycle, so there is no combinational ready path through the FIFO.
- Pop condition: pop = rd_valid & rd_ready. rd_valid = (count != 0).
- Entry format: {wr_sel, wr_data, zero, ones}. zero and ones are computed at write time from wr_data and stored, so the read side has no arithmetic.
- ones is the sum of the 4 data bits, zero-extended to 3 bits.
- Read side is first-word-fall-through: rd_* show the head entry whenever rd_valid=1. When rd_valid=0, rd_data, rd_sel, rd_zero and rd_ones are driven 0.
- Latency: a push at edge N gives rd_valid=1 and the entry on rd_* after edge N, i.e. the following cycle. There is no same-cycle bypass from wr_* to rd_*.
- Pointers increment by 1 per push/pop and wrap from DEPTH-1 to 0 with no special casing.
- count update rules:
  - push only: +1.
  - pop only: -1.
  - push & pop together: unchanged; the head advances and the new entry is written at the tail.
  - neither: unchanged.
- Full and pop in the same cycle: wr_ready=0, so there is no push; count goes to DEPTH-1. Any wr_valid in that cycle counts as an overflow attempt.
- Empty: pop cannot occur. A push in the same cycle is accepted normally.
- Overflow: set when wr_valid=1 and wr_ready=0. The data is dropped and FIFO state is unchanged.
- Overflow set/clear priority: rst > set > clr_ovf. If an overflow attempt and clr_ovf occur in the same cycle, overflow ends 1.
- rd_* values stay stable while rd_valid=1 and rd_ready=0.

Test Plan:
- Reset, then push 0xA/sel 1 in cycle 1 -> cycle 2: rd_valid=1, rd_data=0xA, rd_sel=1, rd_zero=0, rd_ones=2, count=1. Before cycle 2, rd_valid=0.
- Push 0x0, 0xF, 0x3, 0x8 back-to-back with rd_ready=0 -> count=4, wr_ready=0. Then pop 4 times -> rd_data sequence 0x0, 0xF, 0x3, 0x8 with rd_zero 1,0,0,0 and rd_ones 0,4,2,1. Ends with count=0, rd_valid=0.
- Fill to 4, assert wr_valid with 0x5 and rd_ready=1 in the same cycle -> 0x5 dropped, overflow=1, count=3. Assert clr_ovf next cycle with no attempt -> overflow=0.
- Steady stream, push and pop every cycle for 10 cycles with data i&0xF -> count stays 1, pointers wrap at least twice, outputs appear in order with 1-cycle latency.
- With 3 entries queued and overflow=1, assert rst for one cycle alongside wr_valid and rd_ready -> count=0, overflow=0, rd_valid=0, wr_ready=1 the next cycle; no entry was written.
- Overflow attempt coincident with clr_ovf while full -> overflow remains 1.
